dac_seq_ctrl: RTL

Parametrised SPI sequencer for AD5628/AD5668-class octal DACs. After reset it issues the DAC initialisation frames (internal reference on, all channels powered up). It then streams per-channel code updates from a valid/ready write port as 32-bit SPI frames. Pending writes are coalesced and serviced round-robin, with an optional synchronous-update mode. It sits between the board-level control logic and the DAC pins, replacing fixed-table init controllers.

---
 rtl/dac_seq_ctrl.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/dac_seq_ctrl.sv
// dac_seq_ctrl: SPI sequencer for AD5628/AD5668-class octal DACs.
// Sends two init frames, then streams coalesced channel writes round-robin.
module dac_seq_ctrl #(
  parameter int NUM_CH   = 8,
  parameter int DAC_BITS = 12,
  parameter int CLK_DIV  = 5,
  parameter int CS_GAP   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                sync_mode,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [3:0]          wr_ch,
  input  logic [DAC_BITS-1:0] wr_code,
  output logic                sclk,
  output logic                mosi,
  output logic                cs,
  output logic                init_done,
  output logic                busy
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DW = $clog2(CLK_DIV);
  localparam int GW = $clog2(CS_GAP);

  localparam logic [4:0]    NCH      = 5'(NUM_CH);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);
  localparam logic [31:0]   INIT0    = 32'hF800_0001;
  localparam logic [31:0]   INIT1    = 32'hF400_00FF;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DW-1:0] div_cnt;
  logic [5:0]    half_cnt;
  logic [GW-1:0] gap_cnt;
  logic [31:0]   shreg;
  logic [1:0]    init_idx;
  logic          cur_init;

  logic [NUM_CH-1:0]   pending;
  logic [DAC_BITS-1:0] shadow [NUM_CH];
  logic [CW-1:0]       ptr;

  logic          div_last;
  logic          shift_last;
  logic          gap_last;
  logic          wr_fire;
  logic          ch_ok;
  logic [CW-1:0] wr_idx;

  logic          sel_found;
  logic [CW-1:0] sel_ch;
  logic [CW-1:0] ptr_nxt;
  logic          batch_last;
  logic [3:0]    cmd;
  logic [19:0]   code_field;
  logic [31:0]   frame;

  assign div_last   = (div_cnt == DIV_LAST);
  assign shift_last = div_last && (half_cnt == 6'd63);
  assign gap_last   = (gap_cnt == GAP_LAST);
  assign wr_fire    = wr_valid && wr_ready;
  assign ch_ok      = ({1'b0, wr_ch} < NCH);
  assign wr_idx     = wr_ch[CW-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (en && (!init_done || (|pending))) begin
          state_nxt = LOAD;
        end
      end
      LOAD: state_nxt = SHIFT;
      SHIFT: begin
        if (shift_last) begin
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (gap_last) begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  // Round-robin pick of the first pending channel at or after ptr
  always_comb begin
    logic [4:0]        idx;
    logic [4:0]        nxt5;
    logic [NUM_CH-1:0] rest;
    idx       = '0;
    nxt5      = '0;
    rest      = '0;
    sel_found = 1'b0;
    sel_ch    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = 5'(ptr) + 5'(i);
      if (idx >= NCH) begin
        idx = idx - NCH;
      end
      if (!sel_found && pending[idx[CW-1:0]]) begin
        sel_found = 1'b1;
        sel_ch    = idx[CW-1:0];
      end
    end
    nxt5    = 5'(sel_ch) + 5'd1;
    ptr_nxt = (nxt5 >= NCH) ? '0 : nxt5[CW-1:0];
    rest    = pending;
    rest[sel_ch] = 1'b0;
    batch_last = !(|rest) && !wr_fire;
  end

  // Frame assembly: init table until done, then channel update frames
  always_comb begin
    if (!sync_mode) begin
      cmd = 4'b0011;
    end else if (batch_last) begin
      cmd = 4'b0010;
    end else begin
      cmd = 4'b0000;
    end
    code_field = 20'(shadow[sel_ch]) << (20 - DAC_BITS);
    if (!init_done) begin
      frame = (init_idx == 2'd0) ? INIT0 : INIT1;
    end else begin
      frame = {4'hF, cmd, 4'(sel_ch), code_field};
    end
  end

  // Frame datapath: SCLK divider, shift register and init progress
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      half_cnt <= '0;
      gap_cnt  <= '0;
      shreg    <= '0;
      init_idx <= '0;
      cur_init <= 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        LOAD: begin
          shreg    <= frame;
          div_cnt  <= '0;
          half_cnt <= '0;
          gap_cnt  <= '0;
          cur_init <= !init_done;
        end
        SHIFT: begin
          if (div_last) begin
            div_cnt  <= '0;
            half_cnt <= half_cnt + 6'd1;
            if (half_cnt[0] && (half_cnt != 6'd63)) begin
              shreg <= {shreg[30:0], 1'b0};
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + GW'(1);
          if (gap_last && cur_init) begin
            init_idx <= init_idx + 2'd1;
          end
        end
      endcase
    end
  end

  // Shadow codes, pending bits and pointer; a same-cycle write wins
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      ptr     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      if ((state == LOAD) && init_done && sel_found) begin
        pending[sel_ch] <= 1'b0;
        ptr             <= ptr_nxt;
      end
      if (wr_fire && ch_ok) begin
        shadow[wr_idx]  <= wr_code;
        pending[wr_idx] <= 1'b1;
      end
    end
  end

  // Pin and status outputs decoded from state
  always_comb begin
    init_done = (init_idx == 2'd2);
    wr_ready  = init_done;
    busy      = (state != IDLE);
    cs        = !((state == LOAD) || (state == SHIFT));
    sclk      = !((state == SHIFT) && half_cnt[0]);
    if (state == LOAD) begin
      mosi = frame[31];
    end else if (state == SHIFT) begin
      mosi = shreg[31];
    end else begin
      mosi = 1'b0;
    end
  end

endmodule
